// File: rtl/mem_bus_arbiter_if.sv
// Core-side fetch/data ports and fabric-side bus of the memory arbiter.
// The arbiter takes the slave view; the core and fabric together take the master view.
interface mem_bus_arbiter_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_err;

    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    logic        arb_busy;

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata, imem_err,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata, dmem_err,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output arb_busy
    );

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata, imem_err,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata, dmem_err,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  arb_busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the fetch and data ports,
// one transaction at a time, with starvation guard and response timeout.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TLAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          dsel_q, dsel_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   irdata_q, irdata_d;
    logic [31:0]   drdata_q, drdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timer_q, timer_d;

    logic start;
    logic pick_d;
    logic expire;
    logic take;

    assign start  = bus_if.dmem_req | bus_if.imem_req;
    // dmem wins unless imem has waited out STARVE_LIMIT dmem grants
    assign pick_d = bus_if.dmem_req &
                    ~(bus_if.imem_req & (starve_q == SLIM));
    assign expire = (TIMEOUT != 0) && (timer_q == TLAST);
    assign take   = ((state_q == S_ISSUE) & bus_if.bus_gnt & bus_if.bus_rvalid) |
                    ((state_q == S_WAIT) & bus_if.bus_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (take || expire) begin
                    state_d = S_RESP;
                end else if (bus_if.bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (take || expire) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dsel_d   = dsel_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        starve_d = starve_q;
        timer_d  = timer_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dsel_d  = pick_d;
                    timer_d = '0;
                    err_d   = 1'b0;
                    if (pick_d) begin
                        we_d    = bus_if.dmem_we;
                        be_d    = bus_if.dmem_be;
                        addr_d  = bus_if.dmem_addr;
                        wdata_d = bus_if.dmem_wdata;
                    end else begin
                        we_d    = 1'b0;
                        be_d    = 4'b1111;
                        addr_d  = bus_if.imem_addr;
                        wdata_d = '0;
                    end
                    if (pick_d && bus_if.imem_req) begin
                        starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // a response in the expiry cycle beats the timeout
                if (take) begin
                    err_d = bus_if.bus_err;
                    if (dsel_q) begin
                        drdata_d = bus_if.bus_rdata;
                    end else begin
                        irdata_d = bus_if.bus_rdata;
                    end
                end else if (expire) begin
                    err_d = 1'b1;
                    if (dsel_q) begin
                        drdata_d = '0;
                    end else begin
                        irdata_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dsel_q   <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
            starve_q <= '0;
            timer_q  <= '0;
        end else begin
            dsel_q   <= dsel_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            starve_q <= starve_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        bus_if.bus_req    = (state_q == S_ISSUE);
        bus_if.bus_we     = we_q;
        bus_if.bus_be     = be_q;
        bus_if.bus_addr   = addr_q;
        bus_if.bus_wdata  = wdata_q;
        bus_if.imem_ready = (state_q == S_RESP) & ~dsel_q;
        bus_if.dmem_ready = (state_q == S_RESP) & dsel_q;
        bus_if.imem_err   = (state_q == S_RESP) & ~dsel_q & err_q;
        bus_if.dmem_err   = (state_q == S_RESP) & dsel_q & err_q;
        bus_if.imem_rdata = irdata_q;
        bus_if.dmem_rdata = drdata_q;
        bus_if.arb_busy   = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, contention, starvation,
// timeout, bus error and mid-transaction reset.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    mem_bus_arbiter_if bif ();

    mem_bus_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for bus_req, grants it, answers next cycle; returns in RESP cycle.
    task automatic serve(input logic [31:0] rd, input logic er,
                         output logic we, output logic [31:0] ad,
                         output logic ir, output logic dr);
        int n;
        n = 0;
        while (!bif.bus_req && n < 10) begin
            tick();
            n++;
        end
        check("req_seen", 32'(bif.bus_req), 1);
        we = bif.bus_we;
        ad = bif.bus_addr;
        bif.bus_gnt = 1'b1;
        tick();
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = rd;
        bif.bus_err    = er;
        tick();
        bif.bus_rvalid = 1'b0;
        bif.bus_err    = 1'b0;
        ir = bif.imem_ready;
        dr = bif.dmem_ready;
    endtask

    logic        s_we, s_ir, s_dr;
    logic [31:0] s_ad;
    logic [31:0] exp_ad[6];

    initial begin
        bif.imem_req   = 1'b0;
        bif.imem_addr  = '0;
        bif.dmem_req   = 1'b0;
        bif.dmem_we    = 1'b0;
        bif.dmem_be    = '0;
        bif.dmem_addr  = '0;
        bif.dmem_wdata = '0;
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = '0;
        bif.bus_err    = 1'b0;

        tick();
        tick();
        check("rst_bus_req", 32'(bif.bus_req), 0);
        check("rst_busy", 32'(bif.arb_busy), 0);
        check("rst_iready", 32'(bif.imem_ready), 0);
        check("rst_dready", 32'(bif.dmem_ready), 0);
        check("rst_bus_addr", bif.bus_addr, 0);
        rst = 1'b0;

        // lone fetch, zero-wait bus
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h100;
        tick();
        check("f_bus_req", 32'(bif.bus_req), 1);
        check("f_bus_addr", bif.bus_addr, 32'h100);
        check("f_bus_be", 32'(bif.bus_be), 32'hF);
        check("f_bus_we", 32'(bif.bus_we), 0);
        check("f_bus_wdata", bif.bus_wdata, 0);
        bif.bus_gnt = 1'b1;
        tick();
        check("f_wait_req", 32'(bif.bus_req), 0);
        check("f_wait_busy", 32'(bif.arb_busy), 1);
        check("f_wait_iready", 32'(bif.imem_ready), 0);
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hDEADBEEF;
        tick();
        check("f_iready", 32'(bif.imem_ready), 1);
        check("f_irdata", bif.imem_rdata, 32'hDEADBEEF);
        check("f_ierr", 32'(bif.imem_err), 0);
        check("f_dready", 32'(bif.dmem_ready), 0);
        bif.bus_rvalid = 1'b0;
        bif.imem_req   = 1'b0;
        tick();
        check("f_iready_pulse", 32'(bif.imem_ready), 0);
        check("f_irdata_hold", bif.imem_rdata, 32'hDEADBEEF);
        check("f_idle", 32'(bif.arb_busy), 0);

        // simultaneous store and fetch: store first
        bif.imem_req   = 1'b1;
        bif.imem_addr  = 32'h200;
        bif.dmem_req   = 1'b1;
        bif.dmem_we    = 1'b1;
        bif.dmem_be    = 4'b1111;
        bif.dmem_addr  = 32'h2000;
        bif.dmem_wdata = 32'h55AA;
        serve(32'h0, 1'b0, s_we, s_ad, s_ir, s_dr);
        check("c1_we", 32'(s_we), 1);
        check("c1_addr", s_ad, 32'h2000);
        check("c1_wdata", bif.bus_wdata, 32'h55AA);
        check("c1_dready", 32'(s_dr), 1);
        check("c1_iready", 32'(s_ir), 0);
        bif.dmem_req = 1'b0;
        serve(32'h12345678, 1'b0, s_we, s_ad, s_ir, s_dr);
        check("c2_we", 32'(s_we), 0);
        check("c2_addr", s_ad, 32'h200);
        check("c2_iready", 32'(s_ir), 1);
        check("c2_irdata", bif.imem_rdata, 32'h12345678);
        bif.imem_req = 1'b0;
        tick();

        // starvation: d d d d i d with both held
        exp_ad = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h300, 32'h3000};
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h300;
        bif.dmem_req  = 1'b1;
        bif.dmem_we   = 1'b0;
        bif.dmem_addr = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            serve(32'hA0 + 32'(i), 1'b0, s_we, s_ad, s_ir, s_dr);
            check($sformatf("st%0d_addr", i), s_ad, exp_ad[i]);
            check($sformatf("st%0d_iready", i), 32'(s_ir),
                  (exp_ad[i] == 32'h300) ? 1 : 0);
        end
        bif.imem_req = 1'b0;
        bif.dmem_req = 1'b0;
        tick();
        check("st_irdata", bif.imem_rdata, 32'hA4);

        // timeout: gnt but no rvalid, late rvalid ignored
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h400;
        tick();
        check("to_issue", 32'(bif.bus_req), 1);
        bif.bus_gnt = 1'b1;
        tick();
        bif.bus_gnt = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("to_pre_ready", 32'(bif.imem_ready), 0);
        check("to_pre_busy", 32'(bif.arb_busy), 1);
        tick();
        check("to_ready", 32'(bif.imem_ready), 1);
        check("to_err", 32'(bif.imem_err), 1);
        check("to_rdata", bif.imem_rdata, 0);
        check("to_bus_req", 32'(bif.bus_req), 0);
        bif.imem_req   = 1'b0;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hBAD0BAD0;
        tick();
        bif.bus_rvalid = 1'b0;
        check("to_late_ready", 32'(bif.imem_ready), 0);
        check("to_late_err", 32'(bif.imem_err), 0);
        tick();
        check("to_late_busy", 32'(bif.arb_busy), 0);
        check("to_late_rdata", bif.imem_rdata, 0);

        // rvalid in the expiry cycle wins over timeout
        bif.dmem_req  = 1'b1;
        bif.dmem_we   = 1'b0;
        bif.dmem_addr = 32'h700;
        tick();
        bif.bus_gnt = 1'b1;
        tick();
        bif.bus_gnt = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hCAFEF00D;
        tick();
        bif.bus_rvalid = 1'b0;
        bif.dmem_req   = 1'b0;
        check("ex_dready", 32'(bif.dmem_ready), 1);
        check("ex_derr", 32'(bif.dmem_err), 0);
        check("ex_drdata", bif.dmem_rdata, 32'hCAFEF00D);
        tick();

        // bus error on a load, then clean fetch
        bif.dmem_req  = 1'b1;
        bif.dmem_addr = 32'h500;
        serve(32'h11111111, 1'b1, s_we, s_ad, s_ir, s_dr);
        check("be_dready", 32'(s_dr), 1);
        check("be_derr", 32'(bif.dmem_err), 1);
        bif.dmem_req = 1'b0;
        tick();
        check("be_derr_clr", 32'(bif.dmem_err), 0);
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h504;
        serve(32'h22222222, 1'b0, s_we, s_ad, s_ir, s_dr);
        check("be_iready", 32'(s_ir), 1);
        check("be_ierr", 32'(bif.imem_err), 0);
        bif.imem_req = 1'b0;
        tick();

        // reset during WAIT aborts the fetch
        bif.imem_req  = 1'b1;
        bif.imem_addr = 32'h600;
        tick();
        bif.bus_gnt = 1'b1;
        tick();
        bif.bus_gnt  = 1'b0;
        bif.imem_req = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_busy", 32'(bif.arb_busy), 0);
        check("rw_bus_req", 32'(bif.bus_req), 0);
        check("rw_iready", 32'(bif.imem_ready), 0);
        check("rw_bus_addr", bif.bus_addr, 0);
        check("rw_irdata", bif.imem_rdata, 0);
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'h66666666;
        tick();
        bif.bus_rvalid = 1'b0;
        check("rw_late_ready", 32'(bif.imem_ready), 0);
        check("rw_late_busy", 32'(bif.arb_busy), 0);
        bif.imem_req = 1'b1;
        serve(32'h77777777, 1'b0, s_we, s_ad, s_ir, s_dr);
        check("rw_next_addr", s_ad, 32'h600);
        check("rw_next_ready", 32'(s_ir), 1);
        check("rw_next_rdata", bif.imem_rdata, 32'h77777777);
        bif.imem_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
